// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared types and constants for the execute stage
package ex_pkg;

  localparam int XLEN       = 32;
  localparam int REG_AW     = 4;
  localparam int MUL_CYCLES = 32;
  localparam int MUL_CNT_W  = $clog2(MUL_CYCLES);

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_ORR = 4'd3,
    ALU_EOR = 4'd4,
    ALU_LSL = 4'd5,
    ALU_LSR = 4'd6,
    ALU_ASR = 4'd7,
    ALU_MOV = 4'd8,
    ALU_MUL = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic              alusrc;
    logic [3:0]        aluctl;
    logic              rf_we;
    logic              mem_we;
    logic              wbsel;
    logic [REG_AW-1:0] a1;
    logic [REG_AW-1:0] a2;
    logic [REG_AW-1:0] a3;
  } idex_t;

  // The younger producer (MEM) wins over WB when both target the same register.
  function automatic logic [XLEN-1:0] fwd_operand(
    input logic [REG_AW-1:0] addr,
    input logic [XLEN-1:0]   rf_val,
    input logic              we_mem,
    input logic [REG_AW-1:0] a3_mem,
    input logic [XLEN-1:0]   res_mem,
    input logic              we_wb,
    input logic [REG_AW-1:0] a3_wb,
    input logic [XLEN-1:0]   res_wb
  );
    if (we_mem && (a3_mem == addr)) return res_mem;
    if (we_wb && (a3_wb == addr)) return res_wb;
    return rf_val;
  endfunction

endpackage

// File: rtl/mul_iterative.sv
// rtl/mul_iterative.sv - shift-add multiplier, one partial product per cycle
// done_o marks the cycle whose closing edge performs the final step.
module mul_iterative
  import ex_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            done_o,
  output logic [XLEN-1:0] product_o
);

  localparam logic [MUL_CNT_W-1:0] CNT_LAST = MUL_CNT_W'(MUL_CYCLES - 1);

  logic [XLEN-1:0]      mcand_q, mcand_d;
  logic [XLEN-1:0]      mplier_q, mplier_d;
  logic [XLEN-1:0]      prod_q, prod_d;
  logic [MUL_CNT_W-1:0] cnt_q, cnt_d;
  logic                 run_q, run_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (abort_i) begin
      run_d = 1'b0;
    end else if (start_i) begin
      mcand_d  = op_a_i;
      mplier_d = op_b_i;
      prod_d   = '0;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      // Product is kept modulo 2^XLEN, so the multiplicand may shift out freely.
      if (mplier_q[0]) prod_d = prod_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + MUL_CNT_W'(1);
      if (cnt_q == CNT_LAST) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

  assign done_o    = run_q && (cnt_q == CNT_LAST);
  assign product_o = prod_q;

endmodule

// File: rtl/stage_ex.sv
// rtl/stage_ex.sv - execute stage: ID/EX register, operand forwarding, ALU and flags
// Define STAGE_EX_MUL_EN to build the iterative MUL; otherwise opcode 9 yields 0 in one cycle.
module stage_ex
  import ex_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        valid_i,
  input  logic [31:0] RD1_i,
  input  logic [31:0] RD2_i,
  input  logic [31:0] Imm_i,
  input  logic        ALUSrc_i,
  input  logic [3:0]  ALUControl_i,
  input  logic        RF_WE_i,
  input  logic        MemWE_i,
  input  logic        WBSelect_i,
  input  logic [3:0]  A1_i,
  input  logic [3:0]  A2_i,
  input  logic [3:0]  A3_i,
  input  logic        RF_WE_mem,
  input  logic [3:0]  A3_mem,
  input  logic [31:0] AluResult_mem,
  input  logic        RF_WE_wb,
  input  logic [3:0]  A3_wb,
  input  logic [31:0] Result_wb,
  input  logic        flush_i,
  output logic [31:0] RD2_o,
  output logic        RF_WE_o,
  output logic        MemWE_o,
  output logic        WBSelect_o,
  output logic [31:0] AluResult_o,
  output logic [3:0]  A3_o,
  output logic [3:0]  Flags_o,
  output logic        busy_o
);

  idex_t           idex_q, idex_d, in_pkt;
  logic            busy;
  logic [XLEN-1:0] fwd_a, fwd_b, op_b;
  logic [XLEN:0]   sum_w, diff_w;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_res, mul_res;
  logic            fl_c, fl_v, out_en;
  flags_t          flags;

  always_comb begin
    in_pkt        = '0;
    in_pkt.valid  = valid_i;
    in_pkt.rd1    = RD1_i;
    in_pkt.rd2    = RD2_i;
    in_pkt.imm    = Imm_i;
    in_pkt.alusrc = ALUSrc_i;
    in_pkt.aluctl = ALUControl_i;
    in_pkt.rf_we  = RF_WE_i;
    in_pkt.mem_we = MemWE_i;
    in_pkt.wbsel  = WBSelect_i;
    in_pkt.a1     = A1_i;
    in_pkt.a2     = A2_i;
    in_pkt.a3     = A3_i;
  end

  // A flush overrides the stall so an in-flight multiply can be dropped.
  always_comb begin
    idex_d = idex_q;
    if (flush_i) begin
      idex_d        = in_pkt;
      idex_d.valid  = 1'b0;
      idex_d.rf_we  = 1'b0;
      idex_d.mem_we = 1'b0;
    end else if (!busy) begin
      idex_d = in_pkt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  assign fwd_a = fwd_operand(idex_q.a1, idex_q.rd1, RF_WE_mem, A3_mem, AluResult_mem,
                             RF_WE_wb, A3_wb, Result_wb);
  assign fwd_b = fwd_operand(idex_q.a2, idex_q.rd2, RF_WE_mem, A3_mem, AluResult_mem,
                             RF_WE_wb, A3_wb, Result_wb);
  assign op_b   = idex_q.alusrc ? idex_q.imm : fwd_b;
  assign shamt  = op_b[4:0];
  assign sum_w  = {1'b0, fwd_a} + {1'b0, op_b};
  assign diff_w = {1'b0, fwd_a} - {1'b0, op_b};

`ifdef STAGE_EX_MUL_EN
  mul_state_e      state_q, state_d;
  logic            is_mul, mul_start, mul_done;
  logic [XLEN-1:0] mul_product;

  assign is_mul = idex_q.valid && (idex_q.aluctl == ALU_MUL);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= MUL_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    busy      = 1'b0;
    case (state_q)
      MUL_IDLE: begin
        if (is_mul) begin
          busy = 1'b1;
          if (!flush_i) begin
            mul_start = 1'b1;
            state_d   = MUL_RUN;
          end
        end
      end
      MUL_RUN: begin
        busy = 1'b1;
        if (flush_i)       state_d = MUL_IDLE;
        else if (mul_done) state_d = MUL_DONE;
      end
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  mul_iterative u_mul (
    .clk_i     (CLK),
    .rst_i     (RST),
    .start_i   (mul_start),
    .abort_i   (flush_i),
    .op_a_i    (fwd_a),
    .op_b_i    (op_b),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  assign mul_res = (state_q == MUL_DONE) ? mul_product : '0;
`else
  assign busy    = 1'b0;
  assign mul_res = '0;
`endif

  always_comb begin
    alu_res = '0;
    fl_c    = 1'b0;
    fl_v    = 1'b0;
    case (alu_op_e'(idex_q.aluctl))
      ALU_ADD: begin
        alu_res = sum_w[XLEN-1:0];
        fl_c    = sum_w[XLEN];
        fl_v    = (fwd_a[31] == op_b[31]) && (sum_w[31] != fwd_a[31]);
      end
      ALU_SUB: begin
        alu_res = diff_w[XLEN-1:0];
        fl_c    = ~diff_w[XLEN];
        fl_v    = (fwd_a[31] != op_b[31]) && (diff_w[31] != fwd_a[31]);
      end
      ALU_AND: alu_res = fwd_a & op_b;
      ALU_ORR: alu_res = fwd_a | op_b;
      ALU_EOR: alu_res = fwd_a ^ op_b;
      ALU_LSL: alu_res = fwd_a << shamt;
      ALU_LSR: alu_res = fwd_a >> shamt;
      ALU_ASR: alu_res = $unsigned($signed(fwd_a) >>> shamt);
      ALU_MOV: alu_res = op_b;
      ALU_MUL: alu_res = mul_res;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    flags   = '0;
    flags.n = alu_res[31];
    flags.z = (alu_res == '0);
    flags.c = fl_c;
    flags.v = fl_v;
  end

  // Bubbles and reset present an all-zero stage to EX/MEM.
  assign out_en      = idex_q.valid & ~RST;
  assign AluResult_o = out_en ? alu_res : '0;
  assign Flags_o     = out_en ? flags : '0;
  assign RD2_o       = out_en ? fwd_b : '0;
  assign A3_o        = out_en ? idex_q.a3 : '0;
  assign WBSelect_o  = out_en & idex_q.wbsel;
  assign RF_WE_o     = out_en & ~busy & idex_q.rf_we;
  assign MemWE_o     = out_en & ~busy & idex_q.mem_we;
  assign busy_o      = busy & ~RST;

endmodule

// File: tb/tb_stage_ex.sv
// tb/tb_stage_ex.sv - directed self-checking bench for stage_ex
module tb_stage_ex;

  logic        CLK = 1'b0;
  logic        RST;
  logic        valid_i;
  logic [31:0] RD1_i, RD2_i, Imm_i;
  logic        ALUSrc_i;
  logic [3:0]  ALUControl_i;
  logic        RF_WE_i, MemWE_i, WBSelect_i;
  logic [3:0]  A1_i, A2_i, A3_i;
  logic        RF_WE_mem;
  logic [3:0]  A3_mem;
  logic [31:0] AluResult_mem;
  logic        RF_WE_wb;
  logic [3:0]  A3_wb;
  logic [31:0] Result_wb;
  logic        flush_i;
  logic [31:0] RD2_o, AluResult_o;
  logic        RF_WE_o, MemWE_o, WBSelect_o, busy_o;
  logic [3:0]  A3_o, Flags_o;

  int checks = 0;
  int errors = 0;

  stage_ex dut (
    .CLK(CLK), .RST(RST),
    .valid_i(valid_i), .RD1_i(RD1_i), .RD2_i(RD2_i), .Imm_i(Imm_i),
    .ALUSrc_i(ALUSrc_i), .ALUControl_i(ALUControl_i), .RF_WE_i(RF_WE_i),
    .MemWE_i(MemWE_i), .WBSelect_i(WBSelect_i),
    .A1_i(A1_i), .A2_i(A2_i), .A3_i(A3_i),
    .RF_WE_mem(RF_WE_mem), .A3_mem(A3_mem), .AluResult_mem(AluResult_mem),
    .RF_WE_wb(RF_WE_wb), .A3_wb(A3_wb), .Result_wb(Result_wb),
    .flush_i(flush_i),
    .RD2_o(RD2_o), .RF_WE_o(RF_WE_o), .MemWE_o(MemWE_o), .WBSelect_o(WBSelect_o),
    .AluResult_o(AluResult_o), .A3_o(A3_o), .Flags_o(Flags_o), .busy_o(busy_o)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        src;
    logic [31:0] imm;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] rd1,
                       input logic [31:0] rd2, input logic [31:0] imm, input logic src,
                       input logic rfwe, input logic memwe, input logic [3:0] a1,
                       input logic [3:0] a2, input logic [3:0] a3);
    valid_i = v; ALUControl_i = op; RD1_i = rd1; RD2_i = rd2; Imm_i = imm;
    ALUSrc_i = src; RF_WE_i = rfwe; MemWE_i = memwe; WBSelect_i = 1'b0;
    A1_i = a1; A2_i = a2; A3_i = a3;
  endtask

  task automatic fwd_off();
    RF_WE_mem = 1'b0; A3_mem = 4'd0; AluResult_mem = 32'd0;
    RF_WE_wb = 1'b0; A3_wb = 4'd0; Result_wb = 32'd0;
  endtask

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; flush_i = 1'b0;
    drive(1'b1, 4'd0, 32'd5, 32'd6, 32'd0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd7);
    RF_WE_mem = 1'b1; A3_mem = 4'd0; AluResult_mem = 32'h55;
    RF_WE_wb = 1'b0; A3_wb = 4'd0; Result_wb = 32'd0;
    cycle(); cycle();
    checks++;
    if ({AluResult_o, RD2_o, Flags_o, A3_o, RF_WE_o, MemWE_o, WBSelect_o, busy_o} !== 76'd0) begin
      errors++;
      $display("FAIL reset_during got res=%h rd2=%h fl=%b a3=%h we=%b mwe=%b busy=%b exp all zero",
               AluResult_o, RD2_o, Flags_o, A3_o, RF_WE_o, MemWE_o, busy_o);
    end
    RST = 1'b0;
    #1;
    checks++;
    if ({AluResult_o, RD2_o, Flags_o, A3_o, RF_WE_o, MemWE_o, WBSelect_o, busy_o} !== 76'd0) begin
      errors++;
      $display("FAIL reset_after got res=%h rd2=%h fl=%b a3=%h we=%b mwe=%b busy=%b exp all zero",
               AluResult_o, RD2_o, Flags_o, A3_o, RF_WE_o, MemWE_o, busy_o);
    end
    fwd_off();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    cycle();
  endtask

  task automatic test_add_sub();
    drive(1'b1, 4'd0, 32'h7FFFFFFF, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 4'd5);
    WBSelect_i = 1'b1;
    cycle();
    checks++;
    if (AluResult_o !== 32'h80000000 || Flags_o !== 4'b1001) begin
      errors++;
      $display("FAIL add_ovf got %h/%b exp 80000000/1001", AluResult_o, Flags_o);
    end
    checks++;
    if ({RF_WE_o, MemWE_o, WBSelect_o, A3_o, RD2_o} !== {1'b1, 1'b0, 1'b1, 4'd5, 32'd1}) begin
      errors++;
      $display("FAIL add_ctrl got we=%b mwe=%b wbs=%b a3=%h rd2=%h exp 1 0 1 5 00000001",
               RF_WE_o, MemWE_o, WBSelect_o, A3_o, RD2_o);
    end
    drive(1'b1, 4'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 4'd5);
    cycle();
    checks++;
    if (AluResult_o !== 32'd0 || Flags_o !== 4'b0110) begin
      errors++;
      $display("FAIL add_carry got %h/%b exp 00000000/0110", AluResult_o, Flags_o);
    end
    drive(1'b1, 4'd1, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 4'd5);
    cycle();
    checks++;
    if (AluResult_o !== 32'd0 || Flags_o !== 4'b0110) begin
      errors++;
      $display("FAIL sub_zero got %h/%b exp 00000000/0110", AluResult_o, Flags_o);
    end
    drive(1'b1, 4'd1, 32'd3, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 4'd5);
    cycle();
    checks++;
    if (AluResult_o !== 32'hFFFFFFFE || Flags_o !== 4'b1000) begin
      errors++;
      $display("FAIL sub_borrow got %h/%b exp fffffffe/1000", AluResult_o, Flags_o);
    end
    drive(1'b1, 4'd1, 32'h80000000, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 4'd5);
    cycle();
    checks++;
    if (AluResult_o !== 32'h7FFFFFFF || Flags_o !== 4'b0011) begin
      errors++;
      $display("FAIL sub_ovf got %h/%b exp 7fffffff/0011", AluResult_o, Flags_o);
    end
  endtask

  task automatic test_alu_ops();
    vec_t vecs[10];
    vecs[0] = '{4'd2, 32'hF0F000FF, 32'h0FF00F0F, 1'b0, 32'd0, 32'h00F0000F, 4'b0000};
    vecs[1] = '{4'd3, 32'hF0000000, 32'h00000001, 1'b0, 32'd0, 32'hF0000001, 4'b1000};
    vecs[2] = '{4'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0, 32'h00000000, 4'b0100};
    vecs[3] = '{4'd5, 32'h00000001, 32'h00000099, 1'b1, 32'd31, 32'h80000000, 4'b1000};
    vecs[4] = '{4'd5, 32'h00000003, 32'h00000021, 1'b0, 32'd0, 32'h00000006, 4'b0000};
    vecs[5] = '{4'd6, 32'h80000000, 32'h00000004, 1'b0, 32'd0, 32'h08000000, 4'b0000};
    vecs[6] = '{4'd7, 32'h80000000, 32'h00000004, 1'b0, 32'd0, 32'hF8000000, 4'b1000};
    vecs[7] = '{4'd8, 32'h00000055, 32'h00000099, 1'b1, 32'h1234, 32'h00001234, 4'b0000};
    vecs[8] = '{4'd10, 32'h00000007, 32'h00000003, 1'b0, 32'd0, 32'h00000000, 4'b0100};
    vecs[9] = '{4'd15, 32'h00000007, 32'h00000003, 1'b0, 32'd0, 32'h00000000, 4'b0100};
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].src,
            1'b1, 1'b0, 4'd1, 4'd2, 4'd6);
      cycle();
      checks++;
      if (AluResult_o !== vecs[i].res || Flags_o !== vecs[i].fl || RD2_o !== vecs[i].b) begin
        errors++;
        $display("FAIL alu_op%0d got %h/%b rd2=%h exp %h/%b rd2=%h", vecs[i].op, AluResult_o,
                 Flags_o, RD2_o, vecs[i].res, vecs[i].fl, vecs[i].b);
      end
    end
  endtask

  task automatic test_forwarding();
    drive(1'b1, 4'd0, 32'h99, 32'd0, 32'd1, 1'b1, 1'b1, 1'b0, 4'd3, 4'd2, 4'd5);
    RF_WE_mem = 1'b1; A3_mem = 4'd3; AluResult_mem = 32'h10;
    RF_WE_wb = 1'b1; A3_wb = 4'd3; Result_wb = 32'h20;
    cycle();
    checks++;
    if (AluResult_o !== 32'h11) begin
      errors++;
      $display("FAIL fwd_mem_prio got %h exp 00000011", AluResult_o);
    end
    RF_WE_mem = 1'b0;
    #1;
    checks++;
    if (AluResult_o !== 32'h21) begin
      errors++;
      $display("FAIL fwd_wb got %h exp 00000021", AluResult_o);
    end
    RF_WE_wb = 1'b0;
    #1;
    checks++;
    if (AluResult_o !== 32'h9A) begin
      errors++;
      $display("FAIL fwd_none got %h exp 0000009a", AluResult_o);
    end
    drive(1'b1, 4'd0, 32'd1, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd4, 4'd5);
    RF_WE_wb = 1'b1; A3_wb = 4'd4; Result_wb = 32'h20;
    cycle();
    checks++;
    if (AluResult_o !== 32'h21 || RD2_o !== 32'h20) begin
      errors++;
      $display("FAIL fwd_b got res=%h rd2=%h exp 00000021 00000020", AluResult_o, RD2_o);
    end
    fwd_off();
  endtask

  task automatic test_flush_bubble();
    drive(1'b1, 4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 1'b1, 4'd1, 4'd2, 4'd5);
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    checks++;
    if ({RF_WE_o, MemWE_o, AluResult_o} !== 34'd0) begin
      errors++;
      $display("FAIL flush_bubble got we=%b mwe=%b res=%h exp 0 0 0", RF_WE_o, MemWE_o, AluResult_o);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 1'b1, 4'd1, 4'd2, 4'd5);
    cycle();
    checks++;
    if (AluResult_o !== 32'd3 || MemWE_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first got %h mwe=%b exp 00000003 1", AluResult_o, MemWE_o);
    end
    drive(1'b1, 4'd0, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 4'd5);
    cycle();
    checks++;
    if (AluResult_o !== 32'd7 || MemWE_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second got %h mwe=%b exp 00000007 0", AluResult_o, MemWE_o);
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    cycle();
  endtask

`ifdef STAGE_EX_MUL_EN
  task automatic test_mul();
    int busy_cnt;
    int we_in_busy;
    busy_cnt = 0;
    we_in_busy = 0;
    drive(1'b1, 4'd9, 32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 4'd9);
    cycle();
    drive(1'b1, 4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3);
    for (int i = 0; i < 40; i++) begin
      if (!busy_o) break;
      busy_cnt++;
      if (RF_WE_o) we_in_busy++;
      cycle();
    end
    checks++;
    if (busy_cnt !== 33 || we_in_busy !== 0) begin
      errors++;
      $display("FAIL mul_busy got cycles=%0d we_pulses=%0d exp 33 0", busy_cnt, we_in_busy);
    end
    checks++;
    if (AluResult_o !== 32'd42 || RF_WE_o !== 1'b1 || Flags_o !== 4'b0000) begin
      errors++;
      $display("FAIL mul_result got %h we=%b fl=%b exp 0000002a 1 0000", AluResult_o, RF_WE_o, Flags_o);
    end
    cycle();
    checks++;
    if (AluResult_o !== 32'd2 || RF_WE_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL mul_next got %h we=%b busy=%b exp 00000002 0 0", AluResult_o, RF_WE_o, busy_o);
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    cycle();
  endtask

  task automatic test_mul_wrap();
    int waited;
    waited = 0;
    drive(1'b1, 4'd9, 32'hFFFFFFFF, 32'd0, 32'd2, 1'b1, 1'b1, 1'b0, 4'd1, 4'd2, 4'd9);
    cycle();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    while (busy_o && waited < 40) begin
      waited++;
      cycle();
    end
    checks++;
    if (AluResult_o !== 32'hFFFFFFFE || Flags_o !== 4'b1000 || RF_WE_o !== 1'b1) begin
      errors++;
      $display("FAIL mul_wrap got %h/%b we=%b waited=%0d exp fffffffe/1000 1", AluResult_o,
               Flags_o, RF_WE_o, waited);
    end
    cycle();
  endtask

  task automatic test_mul_reset_abort();
    int pulses;
    pulses = 0;
    drive(1'b1, 4'd9, 32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 4'd9);
    cycle();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 10; i++) cycle();
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL mul_run10_busy got %b exp 1", busy_o);
    end
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || RF_WE_o !== 1'b0) begin
      errors++;
      $display("FAIL mul_rst_abort got busy=%b we=%b exp 0 0", busy_o, RF_WE_o);
    end
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (RF_WE_o || busy_o) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL mul_rst_no_write got %0d active cycles exp 0", pulses);
    end
  endtask

  task automatic test_mul_flush_abort();
    int pulses;
    pulses = 0;
    drive(1'b1, 4'd9, 32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 4'd9);
    cycle();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 5; i++) cycle();
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || RF_WE_o !== 1'b0) begin
      errors++;
      $display("FAIL mul_flush_idle got busy=%b we=%b exp 0 0", busy_o, RF_WE_o);
    end
    drive(1'b1, 4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 4'd4);
    cycle();
    checks++;
    if (AluResult_o !== 32'd2 || RF_WE_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL mul_flush_add got %h we=%b busy=%b exp 00000002 1 0", AluResult_o, RF_WE_o, busy_o);
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (RF_WE_o || busy_o) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL mul_flush_no_write got %0d active cycles exp 0", pulses);
    end
  endtask
`else
  task automatic test_mul_disabled();
    drive(1'b1, 4'd9, 32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 4'd9);
    cycle();
    checks++;
    if (AluResult_o !== 32'd0 || Flags_o !== 4'b0100 || busy_o !== 1'b0 || RF_WE_o !== 1'b1) begin
      errors++;
      $display("FAIL mul_off got %h/%b busy=%b we=%b exp 00000000/0100 0 1", AluResult_o,
               Flags_o, busy_o, RF_WE_o);
    end
    drive(1'b1, 4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 4'd4);
    cycle();
    checks++;
    if (AluResult_o !== 32'd2 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL mul_off_next got %h busy=%b exp 00000002 0", AluResult_o, busy_o);
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_add_sub();
    test_alu_ops();
    test_forwarding();
    test_flush_bubble();
    test_back_to_back();
`ifdef STAGE_EX_MUL_EN
    test_mul();
    test_mul_wrap();
    test_mul_reset_abort();
    test_mul_flush_abort();
`else
    test_mul_disabled();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_ex.md
STAGE_EX -- requirements
Module: stage_ex

Interface
REQ-001 SHALL have ports, in order: CLK in 1, the single clock; RST in 1, synchronous active-high reset sampled on rising CLK.
REQ-002 SHALL have ID-side inputs: valid_i 1; RD1_i 32; RD2_i 32; Imm_i 32; ALUSrc_i 1 (1 selects Imm as B); ALUControl_i 4; RF_WE_i 1; MemWE_i 1; WBSelect_i 1; A1_i 4; A2_i 4; A3_i 4.
REQ-003 SHALL have forwarding inputs: RF_WE_mem 1, A3_mem 4, AluResult_mem 32, RF_WE_wb 1, A3_wb 4, Result_wb 32.
REQ-004 SHALL have flush_i in 1, which inserts a bubble.
REQ-005 SHALL have outputs to the EX/MEM pipe: RD2_o 32, RF_WE_o 1, MemWE_o 1, WBSelect_o 1, AluResult_o 32, A3_o 4, Flags_o 4 {N,Z,C,V}, busy_o 1 (stall to IF/ID).

Function
REQ-006 SHALL hold an internal ID/EX register that loads all ID-side inputs on a rising CLK when busy_o=0; it SHALL hold when busy_o=1.
REQ-007 SHALL apply flush_i=1 (with busy_o=0) so the next edge loads a bubble: valid, RF_WE and MemWE cleared.
REQ-008 SHALL drive outputs combinationally from the ID/EX register, giving one-cycle stage latency.
REQ-009 SHALL force RF_WE_o and MemWE_o to 0 when the register is invalid or busy_o=1.
REQ-010 SHALL forward operand A from the MEM stage when RF_WE_mem=1 and A3_mem==A1, else from WB when RF_WE_wb=1 and A3_wb==A1, else use RD1; MEM has priority. Operand B and RD2_o SHALL use the same rule on A2.
REQ-011 SHALL select B as Imm when ALUSrc=1, and as the forwarded RD2 otherwise. RD2_o SHALL always be the forwarded RD2.
REQ-012 SHALL decode ALUControl as 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 EOR, 5 LSL, 6 LSR, 7 ASR, 8 MOV (result=B), 9 MUL; codes 10-15 yield result 0.
REQ-013 SHALL take every shift amount from B[4:0].
REQ-014 SHALL set flags as follows: N=result[31], Z=(result==0). For ADD, C=carry-out and V=signed overflow. For SUB, C=NOT borrow and V=signed overflow. For all other ops C=V=0.
REQ-015 SHALL run the MUL FSM through states IDLE, RUN, DONE:
- IDLE: a valid MUL in ID/EX raises busy_o, latches the forwarded operands, clears the counter and moves to RUN.
- RUN: performs one shift-add step per cycle for 32 cycles, then moves to DONE.
- DONE: busy_o=0, AluResult_o = low 32 bits of the product, controls pass through; next edge returns to IDLE.
REQ-016 SHALL keep busy_o high for exactly 33 cycles per MUL; the result SHALL appear in the 34th cycle the MUL occupies EX.
REQ-017 SHALL abort a multiply on flush_i=1 during RUN: FSM to IDLE and ID/EX to a bubble on the next edge.
REQ-018 SHALL produce wrap-around products (0xFFFFFFFF*2 = 0xFFFFFFFE) with C=V=0.

Reset
REQ-019 SHALL, on RST=1, clear the ID/EX register and the multiplier registers to 0, set FSM=IDLE and counter=0. While RST=1 and on the cycle after it, all outputs (busy_o included) SHALL be 0.
REQ-020 SHALL treat RST during RUN as an abort: no result and no register-file write.

Configuration
REQ-021 SHALL, with macro STAGE_EX_MUL_EN defined, include the MUL FSM and sub-module.
REQ-022 SHALL, without STAGE_EX_MUL_EN, decode opcode 9 as result 0 with one-cycle latency, keep busy_o tied to 0, and omit the FSM.

Structure
REQ-023 SHALL place the ALU opcode enum, a flags struct {N,Z,C,V}, MUL_CYCLES=32 and the data width 32 in shared package ex_pkg.
REQ-024 SHALL implement the iterative multiplier as sub-module mul_iterative (start, operands, done, product).

Verification
REQ-025 SHALL cover ADD 0x7FFFFFFF+1 -> AluResult_o=0x80000000, Flags=N,V (1001).
REQ-026 SHALL cover SUB 5-5 -> result 0, Flags Z,C (0110).
REQ-027 SHALL cover forwarding: A1=3, RF_WE_mem=1, A3_mem=3, AluResult_mem=0x10, A3_wb=3, Result_wb=0x20, ADD imm 1 -> result 0x11.
REQ-028 SHALL cover MUL 7*6: busy_o high 33 cycles, then AluResult_o=42 with RF_WE_o=1 for exactly one cycle.
REQ-029 SHALL cover RST asserted at RUN cycle 10 -> busy_o=0 next cycle and no RF_WE_o pulse.
REQ-030 SHALL cover flush_i during RUN -> FSM IDLE; the following ADD 1+1 yields 2 one cycle after load.
